sdrc_mport_arb: RTL and testbench

Parametrised multi-port front end for the SDRAM controller core. It arbitrates NCH independent application request channels onto the single app_req interface of sdrc_core. Each channel's write-data and read-return strobes are steered back to the channel that owns the transfer, using in-order channel-ID FIFOs. It sits between the bus adapters (one per master) and sdrc_core, in the sdram_clk domain.

---
 rtl/sdrc_mport_arb.sv | 223 ++++++++++++++++++++++
 tb/tb_sdrc_mport_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_mport_arb.sv
// sdrc_mport_arb
// Multi-port front end for sdrc_core. NCH request channels are arbitrated
// (round-robin or fixed priority) onto the single app_req interface. The
// channel ID of every accepted transfer is queued in an in-order FIFO, one
// per direction. The FIFO head is used to steer write-data selection and the
// write/read beat strobes back to the channel that owns the current transfer.
//
// Handshake: a channel raises ch_req with stable addr/len/wr_n and holds them
// until it sees ch_req_ack high in the same cycle. On the core side, app_req
// holds stable until app_req_ack, and that cycle is the acceptance cycle.
//
// Ports
//   sdram_clk, sdram_resetn        clock, async active-low reset
//   cfg_arb_mode                   0 round-robin, 1 fixed priority (ch0 first)
//   ch_req/_addr/_len/_wr_n        per-channel requests (packed, ch i at i*W)
//   ch_req_ack                     one-hot acceptance back to the channel
//   ch_wr_data, ch_wr_en_n         per-channel write data / active-low BEs
//   ch_wr_next, ch_last_wr         write-beat strobes to the owning channel
//   ch_rd_data                     read data broadcast to all channels
//   ch_rd_valid, ch_last_rd        read-beat strobes to the owning channel
//   app_*                          sdrc_core request / data interface
//   rd_orphan_err                  sticky: read beat seen with no owner queued
module sdrc_mport_arb #(
  parameter int NCH    = 4,
  parameter int CHW    = 2,
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9,
  parameter int DEPTH  = 4
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_resetn,
  input  logic                  cfg_arb_mode,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH*APP_AW-1:0] ch_req_addr,
  input  logic [NCH*APP_RW-1:0] ch_req_len,
  input  logic [NCH-1:0]        ch_req_wr_n,
  output logic [NCH-1:0]        ch_req_ack,
  input  logic [NCH*APP_DW-1:0] ch_wr_data,
  input  logic [NCH*APP_BW-1:0] ch_wr_en_n,
  output logic [NCH-1:0]        ch_wr_next,
  output logic [NCH-1:0]        ch_last_wr,
  output logic [APP_DW-1:0]     ch_rd_data,
  output logic [NCH-1:0]        ch_rd_valid,
  output logic [NCH-1:0]        ch_last_rd,
  output logic                  app_req,
  output logic [APP_AW-1:0]     app_req_addr,
  output logic [APP_RW-1:0]     app_req_len,
  output logic                  app_req_wr_n,
  input  logic                  app_req_ack,
  output logic [APP_DW-1:0]     app_wr_data,
  output logic [APP_BW-1:0]     app_wr_en_n,
  input  logic                  app_wr_next_req,
  input  logic                  app_last_wr,
  input  logic [APP_DW-1:0]     app_rd_data,
  input  logic                  app_rd_valid,
  input  logic                  app_last_rd,
  output logic                  rd_orphan_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [CHW-1:0] gnt_id, rr_ptr, win_id;
  logic           win_vld;
  logic [NCH-1:0] eligible;

  // Unpacked views of the per-channel buses so they can be indexed by ID.
  logic [APP_AW-1:0] addr_a  [NCH];
  logic [APP_RW-1:0] len_a   [NCH];
  logic [APP_DW-1:0] wdata_a [NCH];
  logic [APP_BW-1:0] wen_n_a [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      addr_a[i]  = ch_req_addr[i*APP_AW +: APP_AW];
      len_a[i]   = ch_req_len[i*APP_RW +: APP_RW];
      wdata_a[i] = ch_wr_data[i*APP_DW +: APP_DW];
      wen_n_a[i] = ch_wr_en_n[i*APP_BW +: APP_BW];
    end
  end

  // Owner-ID FIFOs. Pointers carry one extra wrap bit so full and empty are
  // distinguishable from the pointer difference alone.
  logic [CHW-1:0] wr_mem [DEPTH];
  logic [CHW-1:0] rd_mem [DEPTH];
  logic [PW:0]    wr_wptr, wr_rptr, rd_wptr, rd_rptr;
  logic [PW:0]    wr_cnt, rd_cnt;
  logic           wr_full, wr_empty, rd_full, rd_empty;
  logic           grant_ack, wr_push, rd_push, wr_pop, rd_pop;
  logic [CHW-1:0] wh, rh;

  assign wr_cnt   = wr_wptr - wr_rptr;
  assign rd_cnt   = rd_wptr - rd_rptr;
  assign wr_full  = (wr_cnt == (PW+1)'(DEPTH));
  assign rd_full  = (rd_cnt == (PW+1)'(DEPTH));
  assign wr_empty = (wr_cnt == '0);
  assign rd_empty = (rd_cnt == '0);
  assign wh       = wr_mem[wr_rptr[PW-1:0]];
  assign rh       = rd_mem[rd_rptr[PW-1:0]];

  assign grant_ack = (state == GRANT) && app_req_ack;
  assign wr_push   = grant_ack && !ch_req_wr_n[gnt_id];
  assign rd_push   = grant_ack &&  ch_req_wr_n[gnt_id];
  // Pops are qualified by non-empty so a stray strobe cannot underflow.
  assign wr_pop    = !wr_empty && app_wr_next_req && app_last_wr;
  assign rd_pop    = !rd_empty && app_rd_valid && app_last_rd;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      wr_wptr <= '0;
      wr_rptr <= '0;
      rd_wptr <= '0;
      rd_rptr <= '0;
    end else begin
      if (wr_push) wr_wptr <= wr_wptr + (PW+1)'(1);
      if (wr_pop)  wr_rptr <= wr_rptr + (PW+1)'(1);
      if (rd_push) rd_wptr <= rd_wptr + (PW+1)'(1);
      if (rd_pop)  rd_rptr <= rd_rptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge sdram_clk) begin
    if (wr_push) wr_mem[wr_wptr[PW-1:0]] <= gnt_id;
    if (rd_push) rd_mem[rd_wptr[PW-1:0]] <= gnt_id;
  end

  // A channel is only eligible if the FIFO for its direction has room, so a
  // push can never hit a full FIFO.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = ch_req[i] && (ch_req_wr_n[i] ? !rd_full : !wr_full);
    end
  end

  // Scan candidates from last to first so the first one in search order is
  // the final assignment and wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (cfg_arb_mode) begin
        idx = k;
      end else begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
      end
      if (eligible[idx[CHW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[CHW-1:0];
      end
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state  <= IDLE;
      gnt_id <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) gnt_id <= win_id;
      if (grant_ack) rr_ptr <= (gnt_id == CHW'(NCH - 1)) ? '0 : gnt_id + CHW'(1);
    end
  end

  // The grant is held until the core acks, even if the channel withdraws.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANT;
      GRANT:   if (app_req_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    app_req      = 1'b0;
    app_req_addr = '0;
    app_req_len  = '0;
    app_req_wr_n = 1'b0;
    ch_req_ack   = '0;
    if (state == GRANT) begin
      app_req            = 1'b1;
      app_req_addr       = addr_a[gnt_id];
      app_req_len        = len_a[gnt_id];
      app_req_wr_n       = ch_req_wr_n[gnt_id];
      ch_req_ack[gnt_id] = app_req_ack;
    end

    app_wr_data = '0;
    app_wr_en_n = '1;
    ch_wr_next  = '0;
    ch_last_wr  = '0;
    if (!wr_empty) begin
      app_wr_data    = wdata_a[wh];
      app_wr_en_n    = wen_n_a[wh];
      ch_wr_next[wh] = app_wr_next_req;
      ch_last_wr[wh] = app_last_wr;
    end

    ch_rd_valid = '0;
    ch_last_rd  = '0;
    if (!rd_empty) begin
      ch_rd_valid[rh] = app_rd_valid;
      ch_last_rd[rh]  = app_rd_valid && app_last_rd;
    end
  end

  assign ch_rd_data = app_rd_data;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn)                rd_orphan_err <= 1'b0;
    else if (app_rd_valid && rd_empty) rd_orphan_err <= 1'b1;
  end

endmodule

// File: tb/tb_sdrc_mport_arb.sv
module tb_sdrc_mport_arb;

  localparam int NCH = 4, CHW = 2, APP_AW = 26, APP_DW = 32;
  localparam int APP_BW = 4, APP_RW = 9, DEPTH = 4;

  logic                  sdram_clk, sdram_resetn, cfg_arb_mode;
  logic [NCH-1:0]        ch_req, ch_req_wr_n, ch_req_ack;
  logic [NCH*APP_AW-1:0] ch_req_addr;
  logic [NCH*APP_RW-1:0] ch_req_len;
  logic [NCH*APP_DW-1:0] ch_wr_data;
  logic [NCH*APP_BW-1:0] ch_wr_en_n;
  logic [NCH-1:0]        ch_wr_next, ch_last_wr, ch_rd_valid, ch_last_rd;
  logic [APP_DW-1:0]     ch_rd_data, app_wr_data, app_rd_data;
  logic                  app_req, app_req_wr_n, app_req_ack;
  logic [APP_AW-1:0]     app_req_addr;
  logic [APP_RW-1:0]     app_req_len;
  logic [APP_BW-1:0]     app_wr_en_n;
  logic                  app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd;
  logic                  rd_orphan_err;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  sdrc_mport_arb #(
    .NCH(NCH), .CHW(CHW), .APP_AW(APP_AW), .APP_DW(APP_DW),
    .APP_BW(APP_BW), .APP_RW(APP_RW), .DEPTH(DEPTH)
  ) dut (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .cfg_arb_mode(cfg_arb_mode),
    .ch_req(ch_req), .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
    .ch_req_wr_n(ch_req_wr_n), .ch_req_ack(ch_req_ack),
    .ch_wr_data(ch_wr_data), .ch_wr_en_n(ch_wr_en_n),
    .ch_wr_next(ch_wr_next), .ch_last_wr(ch_last_wr),
    .ch_rd_data(ch_rd_data), .ch_rd_valid(ch_rd_valid), .ch_last_rd(ch_last_rd),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .rd_orphan_err(rd_orphan_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sdram_clk);
    #2;
  endtask

  // ---------------- stimulus knobs ----------------
  int ack_pct = 100, beat_pct = 100, gap_pct = 100;
  bit orphan_inject = 1'b0;
  int budget [NCH];    // requests still to issue per channel
  int dir_mode [NCH];  // 0 random, 1 write, 2 read
  int fix_len [NCH];   // 0 random 1..4
  bit ack_seen [NCH];

  // ---------------- channel drivers ----------------
  task automatic new_req(input int i);
    ch_req[i] = 1'b1;
    ch_req_addr[i*APP_AW +: APP_AW] = APP_AW'($urandom);
    ch_req_len[i*APP_RW +: APP_RW] = (fix_len[i] != 0) ? APP_RW'(fix_len[i])
                                                       : APP_RW'($urandom_range(4, 1));
    ch_req_wr_n[i] = (dir_mode[i] == 1) ? 1'b0 :
                     (dir_mode[i] == 2) ? 1'b1 : 1'($urandom_range(1, 0));
  endtask

  always @(posedge sdram_clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      ch_wr_data[i*APP_DW +: APP_DW] = $urandom;
      ch_wr_en_n[i*APP_BW +: APP_BW] = APP_BW'($urandom);
      if (ack_seen[i]) begin
        ack_seen[i] = 1'b0;
        budget[i]--;
        ch_req[i] = 1'b0;
      end
      if (!ch_req[i] && budget[i] > 0 && $urandom_range(99, 0) < gap_pct) new_req(i);
    end
  end

  // ---------------- core-side driver ----------------
  int bw_q [$];  // remaining beats of accepted writes, in order
  int br_q [$];  // remaining beats of accepted reads, in order

  always @(posedge sdram_clk) begin
    #1;
    app_req_ack = 1'b0;
    app_wr_next_req = 1'b0;
    app_last_wr = 1'b0;
    app_rd_valid = 1'b0;
    app_last_rd = 1'b0;
    app_rd_data = '0;
    if (!sdram_resetn) begin
      bw_q.delete();
      br_q.delete();
    end else begin
      app_req_ack = app_req && ($urandom_range(99, 0) < ack_pct);
      if (bw_q.size() > 0 && $urandom_range(99, 0) < beat_pct) begin
        app_wr_next_req = 1'b1;
        app_last_wr = (bw_q[0] == 1);
      end
      if (br_q.size() > 0 && $urandom_range(99, 0) < beat_pct) begin
        app_rd_valid = 1'b1;
        app_last_rd = (br_q[0] == 1);
        app_rd_data = $urandom;
      end else if (orphan_inject) begin
        app_rd_valid = 1'b1;
        app_last_rd = 1'b1;
        app_rd_data = $urandom;
        orphan_inject = 1'b0;
      end
    end
  end

  always @(negedge sdram_clk) begin
    if (sdram_resetn) begin
      if (app_wr_next_req && bw_q.size() > 0) begin
        bw_q[0] = bw_q[0] - 1;
        if (bw_q[0] == 0) void'(bw_q.pop_front());
      end
      if (app_rd_valid && br_q.size() > 0) begin
        br_q[0] = br_q[0] - 1;
        if (br_q[0] == 0) void'(br_q.pop_front());
      end
      if (app_req && app_req_ack) begin
        if (app_req_wr_n) br_q.push_back(int'(app_req_len));
        else              bw_q.push_back(int'(app_req_len));
      end
    end
  end

  // ---------------- observation counters ----------------
  int grant_log [$];
  int ack_cnt [NCH], wrn_cnt [NCH], lastw_cnt [NCH], rdv_cnt [NCH];

  task automatic clear_counts();
    grant_log.delete();
    for (int i = 0; i < NCH; i++) begin
      ack_cnt[i] = 0; wrn_cnt[i] = 0; lastw_cnt[i] = 0; rdv_cnt[i] = 0;
    end
  endtask

  always @(negedge sdram_clk) begin
    if (sdram_resetn) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_req_ack[i]) begin
          ack_seen[i] = 1'b1;
          grant_log.push_back(i);
          ack_cnt[i]++;
        end
        if (ch_wr_next[i])  wrn_cnt[i]++;
        if (ch_last_wr[i])  lastw_cnt[i]++;
        if (ch_rd_valid[i]) rdv_cnt[i]++;
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_gnt = -1;     // channel currently presented to the core, -1 none
  int m_rr = 0;       // round-robin search start
  int m_wq [$];       // owners of outstanding writes, oldest first
  int m_rq [$];       // owners of outstanding reads, oldest first
  bit m_orph = 1'b0;

  function automatic int pick(input logic [NCH-1:0] elig, input logic fixed, input int rr);
    if (fixed) begin
      for (int i = 0; i < NCH; i++) if (elig[i]) return i;
    end else begin
      for (int k = 0; k < NCH; k++) if (elig[(rr + k) % NCH]) return (rr + k) % NCH;
    end
    return -1;
  endfunction

  logic              e_req, e_wrn;
  logic [APP_AW-1:0] e_addr;
  logic [APP_RW-1:0] e_len;
  logic [NCH-1:0]    e_ack, e_wnext, e_wlast, e_rvalid, e_rlast, m_elig;
  logic [APP_DW-1:0] e_wdata;
  logic [APP_BW-1:0] e_wen;
  bit                m_wpop, m_rpop;

  always @(negedge sdram_clk) begin
    if (!sdram_resetn) begin
      m_gnt = -1; m_rr = 0; m_wq.delete(); m_rq.delete(); m_orph = 1'b0;
    end
    e_req = 1'b0; e_addr = '0; e_len = '0; e_wrn = 1'b0; e_ack = '0;
    if (m_gnt >= 0) begin
      e_req = 1'b1;
      e_addr = ch_req_addr[m_gnt*APP_AW +: APP_AW];
      e_len = ch_req_len[m_gnt*APP_RW +: APP_RW];
      e_wrn = ch_req_wr_n[m_gnt];
      e_ack[m_gnt] = app_req_ack;
    end
    e_wdata = '0; e_wen = '1; e_wnext = '0; e_wlast = '0;
    if (m_wq.size() > 0) begin
      e_wdata = ch_wr_data[m_wq[0]*APP_DW +: APP_DW];
      e_wen = ch_wr_en_n[m_wq[0]*APP_BW +: APP_BW];
      e_wnext[m_wq[0]] = app_wr_next_req;
      e_wlast[m_wq[0]] = app_last_wr;
    end
    e_rvalid = '0; e_rlast = '0;
    if (m_rq.size() > 0) begin
      e_rvalid[m_rq[0]] = app_rd_valid;
      e_rlast[m_rq[0]] = app_rd_valid & app_last_rd;
    end
    chk("app_req", app_req, e_req);
    chk("app_req_addr", app_req_addr, e_addr);
    chk("app_req_len", app_req_len, e_len);
    chk("app_req_wr_n", app_req_wr_n, e_wrn);
    chk("ch_req_ack", ch_req_ack, e_ack);
    chk("app_wr_data", app_wr_data, e_wdata);
    chk("app_wr_en_n", app_wr_en_n, e_wen);
    chk("ch_wr_next", ch_wr_next, e_wnext);
    chk("ch_last_wr", ch_last_wr, e_wlast);
    chk("ch_rd_data", ch_rd_data, app_rd_data);
    chk("ch_rd_valid", ch_rd_valid, e_rvalid);
    chk("ch_last_rd", ch_last_rd, e_rlast);
    chk("rd_orphan_err", rd_orphan_err, m_orph);

    if (sdram_resetn) begin
      for (int i = 0; i < NCH; i++)
        m_elig[i] = ch_req[i] && (ch_req_wr_n[i] ? (m_rq.size() < DEPTH) : (m_wq.size() < DEPTH));
      m_wpop = (m_wq.size() > 0) && app_wr_next_req && app_last_wr;
      m_rpop = (m_rq.size() > 0) && app_rd_valid && app_last_rd;
      if (app_rd_valid && m_rq.size() == 0) m_orph = 1'b1;
      if (m_wpop) void'(m_wq.pop_front());
      if (m_rpop) void'(m_rq.pop_front());
      if (m_gnt >= 0) begin
        if (app_req_ack) begin
          if (ch_req_wr_n[m_gnt]) m_rq.push_back(m_gnt);
          else                    m_wq.push_back(m_gnt);
          m_rr = (m_gnt + 1) % NCH;
          m_gnt = -1;
        end
      end else begin
        m_gnt = pick(m_elig, cfg_arb_mode, m_rr);
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  function automatic int log_at(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  task automatic wait_drain(input int limit, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      tick(1);
      n++;
      done = (budget.sum() == 0) && (ch_req == '0) && !app_req &&
             (bw_q.size() == 0) && (br_q.size() == 0);
    end
    chk(name, done, 1'b1);
  endtask

  task automatic set_all(input int b, input int dm, input int fl);
    for (int i = 0; i < NCH; i++) begin
      budget[i] = b; dir_mode[i] = dm; fix_len[i] = fl;
    end
  endtask

  initial begin
    int n;
    sdram_resetn = 1'b0;
    cfg_arb_mode = 1'b0;
    ch_req = '0; ch_req_addr = '0; ch_req_len = '0; ch_req_wr_n = '0;
    ch_wr_data = '0; ch_wr_en_n = '0;
    app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_last_wr = 1'b0;
    app_rd_data = '0; app_rd_valid = 1'b0; app_last_rd = 1'b0;
    set_all(0, 0, 0);
    for (int i = 0; i < NCH; i++) ack_seen[i] = 1'b0;
    clear_counts();
    tick(3);
    chk("rst_app_req", app_req, 1'b0);
    chk("rst_app_wr_en_n", app_wr_en_n, 4'hF);
    chk("rst_orphan", rd_orphan_err, 1'b0);
    sdram_resetn = 1'b1;
    tick(2);

    // Round-robin, all channels reading.
    set_all(2, 2, 1);
    wait_drain(300, "rr_drain");
    chk("rr_cnt", grant_log.size(), 8);
    chk("rr_g0", log_at(0), 0);
    chk("rr_g1", log_at(1), 1);
    chk("rr_g2", log_at(2), 2);
    chk("rr_g3", log_at(3), 3);
    chk("rr_g4", log_at(4), 0);

    // Fixed priority: ch1 keeps requesting, ch3 waits.
    clear_counts();
    cfg_arb_mode = 1'b1;
    set_all(0, 0, 0);
    budget[1] = 3; budget[3] = 1;
    wait_drain(300, "fp_drain");
    chk("fp_cnt", grant_log.size(), 4);
    chk("fp_g0", log_at(0), 1);
    chk("fp_g2", log_at(2), 1);
    chk("fp_g3", log_at(3), 3);

    // ch2 write len 4, then ch0 read len 2.
    clear_counts();
    cfg_arb_mode = 1'b0;
    dir_mode[2] = 1; fix_len[2] = 4; budget[2] = 1;
    tick(1);
    dir_mode[0] = 2; fix_len[0] = 2; budget[0] = 1;
    wait_drain(300, "il_drain");
    chk("il_wnext2", wrn_cnt[2], 4);
    chk("il_wlast2", lastw_cnt[2], 1);
    chk("il_wnext_other", wrn_cnt[0] + wrn_cnt[1] + wrn_cnt[3], 0);
    chk("il_rvalid0", rdv_cnt[0], 2);
    chk("il_rvalid_other", rdv_cnt[1] + rdv_cnt[2] + rdv_cnt[3], 0);
    chk("il_wr_en_idle", app_wr_en_n, 4'hF);

    // Write FIFO full: five writes from ch1 with no beats returned.
    clear_counts();
    set_all(0, 1, 1);
    beat_pct = 0;
    budget[1] = 5;
    tick(30);
    chk("full_acks", ack_cnt[1], 4);
    chk("full_masked", app_req, 1'b0);
    beat_pct = 100;
    wait_drain(300, "full_drain");
    chk("full_acks_after", ack_cnt[1], 5);

    // Orphan read beat.
    clear_counts();
    orphan_inject = 1'b1;
    tick(3);
    chk("orphan_set", rd_orphan_err, 1'b1);
    chk("orphan_no_valid", rdv_cnt.sum(), 0);
    tick(10);
    chk("orphan_sticky", rd_orphan_err, 1'b1);

    // Reset in the middle of a write burst.
    set_all(0, 0, 0);
    dir_mode[2] = 1; fix_len[2] = 8; budget[2] = 1;
    n = 0;
    while (!app_wr_next_req && n < 100) begin
      tick(1);
      n++;
    end
    chk("mid_burst_seen", app_wr_next_req, 1'b1);
    tick(1);
    sdram_resetn = 1'b0;
    #1;
    chk("mrst_wr_en_n", app_wr_en_n, 4'hF);
    chk("mrst_wr_next", ch_wr_next, '0);
    chk("mrst_wr_data", app_wr_data, '0);
    chk("mrst_orphan", rd_orphan_err, 1'b0);
    for (int i = 0; i < NCH; i++) ack_seen[i] = 1'b0;
    clear_counts();
    set_all(0, 2, 1);
    budget[0] = 1; budget[3] = 1;
    tick(2);
    sdram_resetn = 1'b1;
    wait_drain(300, "mrst_drain");
    chk("mrst_first_grant", log_at(0), 0);

    // Randomized traffic in both arbitration modes.
    for (int r = 0; r < 2; r++) begin
      cfg_arb_mode = 1'(r);
      ack_pct = 60; beat_pct = 50; gap_pct = 40;
      set_all(25, 0, 0);
      wait_drain(8000, "rand_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
